// File: rtl/chart_pkg.sv
// rtl/chart_pkg.sv - shared types and constants for the chart recorder
package chart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REC,
    S_DONE,
    S_PLAY,
    S_END
  } state_t;

  localparam int TS_MAX_W = 32;
  localparam int TRK_UP   = 0;
  localparam int TRK_DOWN = 1;

  // ts is held at full game-time width here; the chart RAM keeps only the low TS_W bits
  typedef struct packed {
    logic [TS_MAX_W-1:0] ts;
    logic [1:0]          trk;
  } entry_t;

endpackage

// File: rtl/chart_recorder_if.sv
// rtl/chart_recorder_if.sv - command, press and replay-note bundle of the chart recorder
interface chart_recorder_if #(
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   i_cur_time;
  logic          i_arm;
  logic          i_stop;
  logic          i_replay;
  logic [1:0]    i_play;
  logic          o_note_t1;
  logic          o_note_t2;
  logic          o_game_end;
  logic          o_recording;
  logic [CW-1:0] o_count;
  logic          o_overflow;

  modport master (
    output i_cur_time, i_arm, i_stop, i_replay, i_play,
    input  o_note_t1, o_note_t2, o_game_end, o_recording, o_count, o_overflow
  );

  modport slave (
    input  i_cur_time, i_arm, i_stop, i_replay, i_play,
    output o_note_t1, o_note_t2, o_game_end, o_recording, o_count, o_overflow
  );

endinterface

// File: rtl/chart_mem.sv
// rtl/chart_mem.sv - simple dual-port chart RAM, one write port and one registered read port
module chart_mem #(
  parameter int DEPTH = 64,
  parameter int W     = 18,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/chart_recorder.sv
// rtl/chart_recorder.sv - records play-button presses as timestamped chart entries
// and replays them as one-cycle note pulses against the game clock
module chart_recorder #(
  parameter int DEPTH = 64,
  parameter int TS_W  = 16
) (
  input logic             clk,
  input logic             rst,
  chart_recorder_if.slave bus
);
  import chart_pkg::*;

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam int            W        = TS_W + 2;
  localparam logic [31:0]   TS_LIMIT = 32'((64'd1 << TS_W) - 64'd1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  state_t          state;
  state_t          state_nx;
  logic [31:0]     base;
  logic [31:0]     pbase;
  logic [31:0]     rec_diff;
  logic [31:0]     play_diff;
  logic [CW-1:0]   count;
  logic [CW-1:0]   rptr;
  logic            overflow;
  logic            note_t1;
  logic            note_t2;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] last_ts;
  logic [1:0]      last_trk;
  entry_t          pre;
  logic            vld0;
  logic            vld1;
  logic            ts_sat;
  logic            press;
  logic            merge;
  logic            wr_new;
  logic            drop;
  logic            start_play;
  logic            fire;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [W-1:0]    wdata;
  logic [W-1:0]    rdata;

  assign rec_diff  = bus.i_cur_time - base;
  assign play_diff = bus.i_cur_time - pbase;
  assign ts        = rec_diff[TS_W-1:0];

  // arm always wins, so it masks every other action in its cycle
  assign ts_sat     = (state == S_REC) && !bus.i_arm && (rec_diff > TS_LIMIT);
  assign press      = (state == S_REC) && !bus.i_arm && (bus.i_play != 2'b00) && !ts_sat;
  assign merge      = press && (count != '0) && (ts == last_ts);
  assign wr_new     = press && !merge && (count < FULL);
  assign drop       = press && !merge && !wr_new;
  assign start_play = !bus.i_arm && bus.i_replay && ((state == S_DONE) || (state == S_END));
  assign fire       = !bus.i_arm && (state == S_PLAY) && vld1 && (play_diff >= pre.ts);

  // a merge rewrites the last entry using the shadow copy of its track bits
  assign we    = merge || wr_new;
  assign waddr = count[AW-1:0] - AW'(merge);
  assign wdata = {ts, merge ? (last_trk | bus.i_play) : bus.i_play};

  chart_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.i_arm) begin
      state_nx = S_REC;
    end else begin
      case (state)
        S_REC: begin
          if (bus.i_stop || ts_sat) begin
            state_nx = S_DONE;
          end
        end
        S_DONE, S_END: begin
          if (start_play) begin
            state_nx = (count == '0) ? S_END : S_PLAY;
          end
        end
        S_PLAY: begin
          // rptr reaches count on the edge the last note pulses, so END follows one cycle later
          if (rptr == count) begin
            state_nx = S_END;
          end
        end
        default: begin
          state_nx = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base     <= '0;
      pbase    <= '0;
      count    <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      last_ts  <= '0;
      last_trk <= '0;
      pre      <= '0;
      vld0     <= 1'b0;
      vld1     <= 1'b0;
      note_t1  <= 1'b0;
      note_t2  <= 1'b0;
    end else begin
      note_t1 <= 1'b0;
      note_t2 <= 1'b0;
      if (bus.i_arm) begin
        base     <= bus.i_cur_time;
        count    <= '0;
        overflow <= 1'b0;
      end
      if (ts_sat || drop) begin
        overflow <= 1'b1;
      end
      if (wr_new) begin
        count    <= count + 1'b1;
        last_ts  <= ts;
        last_trk <= bus.i_play;
      end
      if (merge) begin
        last_trk <= last_trk | bus.i_play;
      end
      pre <= '{ts: TS_MAX_W'(rdata[W-1:2]), trk: rdata[1:0]};
      // vld0: RAM output matches rptr; vld1: prefetch register matches rptr
      if (start_play) begin
        pbase <= bus.i_cur_time;
        rptr  <= '0;
        vld0  <= 1'b0;
        vld1  <= 1'b0;
      end else if (fire) begin
        note_t1 <= pre.trk[TRK_UP];
        note_t2 <= pre.trk[TRK_DOWN];
        rptr    <= rptr + 1'b1;
        vld0    <= 1'b0;
        vld1    <= 1'b0;
      end else begin
        vld0 <= 1'b1;
        vld1 <= vld0;
      end
    end
  end

  assign bus.o_note_t1   = note_t1;
  assign bus.o_note_t2   = note_t2;
  assign bus.o_game_end  = (state == S_END);
  assign bus.o_recording = (state == S_REC);
  assign bus.o_count     = count;
  assign bus.o_overflow  = overflow;

endmodule

// File: tb/tb_chart_recorder.sv
// tb/tb_chart_recorder.sv - directed self-checking bench for chart_recorder
`timescale 1ns/1ps
module tb_chart_recorder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  chart_recorder_if #(.DEPTH(64)) ifa ();
  chart_recorder_if #(.DEPTH(4))  ifb ();

  chart_recorder #(.DEPTH(64), .TS_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  chart_recorder #(.DEPTH(4),  .TS_W(8))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cmd(input logic arm, input logic stop, input logic replay,
                       input logic [1:0] play, input logic [31:0] t);
    ifa.i_cur_time = t;
    ifa.i_arm = arm; ifa.i_stop = stop; ifa.i_replay = replay; ifa.i_play = play;
    tick();
    ifa.i_arm = 1'b0; ifa.i_stop = 1'b0; ifa.i_replay = 1'b0; ifa.i_play = 2'b00;
  endtask

  task automatic b_cmd(input logic arm, input logic stop, input logic replay,
                       input logic [1:0] play, input logic [31:0] t);
    ifb.i_cur_time = t;
    ifb.i_arm = arm; ifb.i_stop = stop; ifb.i_replay = replay; ifb.i_play = play;
    tick();
    ifb.i_arm = 1'b0; ifb.i_stop = 1'b0; ifb.i_replay = 1'b0; ifb.i_play = 2'b00;
  endtask

  task automatic test_reset();
    #5 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ifa.o_note_t1, ifa.o_note_t2, ifa.o_game_end, ifa.o_recording, ifa.o_overflow} !== 5'b0
        || ifa.o_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_a: got flags %b count %0d, expected 00000 and 0",
               {ifa.o_note_t1, ifa.o_note_t2, ifa.o_game_end, ifa.o_recording, ifa.o_overflow}, ifa.o_count);
    end
    checks++;
    if ({ifb.o_note_t1, ifb.o_note_t2, ifb.o_game_end, ifb.o_recording, ifb.o_overflow} !== 5'b0
        || ifb.o_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_b: got flags %b count %0d, expected 00000 and 0",
               {ifb.o_note_t1, ifb.o_note_t2, ifb.o_game_end, ifb.o_recording, ifb.o_overflow}, ifb.o_count);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_record_replay();
    int n1 = 0;
    int n2 = 0;
    int t1a = -1;
    int t1b = -1;
    int t2a = -1;
    int end_at = -1;
    a_cmd(1, 0, 0, 2'b00, 1000);
    checks++;
    if (ifa.o_recording !== 1'b1 || ifa.o_count !== 7'd0) begin
      errors++;
      $display("FAIL arm_state: got rec %b count %0d, expected 1 and 0", ifa.o_recording, ifa.o_count);
    end
    a_cmd(0, 0, 0, 2'b01, 1100);
    a_cmd(0, 0, 0, 2'b10, 1250);
    a_cmd(0, 1, 0, 2'b01, 1400);
    checks++;
    if (ifa.o_count !== 7'd3 || ifa.o_recording !== 1'b0 || ifa.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL record_count: got count %0d rec %b ovf %b, expected 3 0 0",
               ifa.o_count, ifa.o_recording, ifa.o_overflow);
    end
    a_cmd(0, 0, 1, 2'b00, 5000);
    for (int t = 5000; t < 5420; t++) begin
      ifa.i_cur_time = t;
      tick();
      if (ifa.o_note_t1) begin
        if (n1 == 0) t1a = t; else if (n1 == 1) t1b = t;
        n1++;
      end
      if (ifa.o_note_t2) begin
        if (n2 == 0) t2a = t;
        n2++;
      end
      if (ifa.o_game_end && end_at < 0) end_at = t;
    end
    checks++;
    if (n1 != 2 || t1a != 5100 || t1b != 5400) begin
      errors++;
      $display("FAIL replay_t1: got %0d notes at %0d,%0d, expected 2 at 5100,5400", n1, t1a, t1b);
    end
    checks++;
    if (n2 != 1 || t2a != 5250) begin
      errors++;
      $display("FAIL replay_t2: got %0d notes at %0d, expected 1 at 5250", n2, t2a);
    end
    checks++;
    if (end_at != 5401) begin
      errors++;
      $display("FAIL game_end_time: got %0d, expected 5401", end_at);
    end
    checks++;
    if (ifa.o_count !== 7'd3) begin
      errors++;
      $display("FAIL chart_retained: got %0d, expected 3", ifa.o_count);
    end
  endtask

  task automatic test_merge();
    int both_at = -1;
    int pulses = 0;
    a_cmd(1, 0, 0, 2'b00, 2000);
    checks++;
    if (ifa.o_game_end !== 1'b0 || ifa.o_recording !== 1'b1) begin
      errors++;
      $display("FAIL rearm: got end %b rec %b, expected 0 1", ifa.o_game_end, ifa.o_recording);
    end
    a_cmd(0, 0, 0, 2'b11, 2010);
    a_cmd(0, 0, 0, 2'b01, 2010);
    checks++;
    if (ifa.o_count !== 7'd1) begin
      errors++;
      $display("FAIL merge_count: got %0d, expected 1", ifa.o_count);
    end
    a_cmd(0, 1, 0, 2'b00, 2010);
    a_cmd(0, 0, 1, 2'b00, 3000);
    for (int t = 3000; t < 3030; t++) begin
      ifa.i_cur_time = t;
      tick();
      if (ifa.o_note_t1 || ifa.o_note_t2) pulses++;
      if (ifa.o_note_t1 && ifa.o_note_t2) both_at = t;
    end
    checks++;
    if (pulses != 1 || both_at != 3010) begin
      errors++;
      $display("FAIL merge_replay: got %0d note cycles, both at %0d, expected 1 at 3010", pulses, both_at);
    end
  endtask

  task automatic test_full();
    int notes = 0;
    b_cmd(1, 0, 0, 2'b00, 100);
    for (int i = 0; i < 6; i++) begin
      b_cmd(0, 0, 0, (i % 2 == 0) ? 2'b01 : 2'b10, 110 + i);
    end
    checks++;
    if (ifb.o_count !== 3'd4 || ifb.o_overflow !== 1'b1 || ifb.o_recording !== 1'b1) begin
      errors++;
      $display("FAIL full: got count %0d ovf %b rec %b, expected 4 1 1",
               ifb.o_count, ifb.o_overflow, ifb.o_recording);
    end
    b_cmd(0, 1, 0, 2'b00, 120);
    b_cmd(0, 0, 1, 2'b00, 1000);
    for (int t = 1000; t < 1060; t++) begin
      ifb.i_cur_time = t;
      tick();
      if (ifb.o_note_t1 || ifb.o_note_t2) notes++;
    end
    checks++;
    if (notes != 4 || ifb.o_game_end !== 1'b1) begin
      errors++;
      $display("FAIL full_replay: got %0d notes end %b, expected 4 and 1", notes, ifb.o_game_end);
    end
  endtask

  task automatic test_saturation();
    b_cmd(1, 0, 0, 2'b00, 500);
    checks++;
    if (ifb.o_overflow !== 1'b0 || ifb.o_count !== 3'd0) begin
      errors++;
      $display("FAIL arm_clears: got ovf %b count %0d, expected 0 0", ifb.o_overflow, ifb.o_count);
    end
    b_cmd(0, 0, 0, 2'b01, 755);
    checks++;
    if (ifb.o_count !== 3'd1 || ifb.o_recording !== 1'b1) begin
      errors++;
      $display("FAIL ts_max_edge: got count %0d rec %b, expected 1 1", ifb.o_count, ifb.o_recording);
    end
    b_cmd(0, 0, 0, 2'b10, 800);
    checks++;
    if (ifb.o_count !== 3'd1 || ifb.o_recording !== 1'b0 || ifb.o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL saturation: got count %0d rec %b ovf %b, expected 1 0 1",
               ifb.o_count, ifb.o_recording, ifb.o_overflow);
    end
  endtask

  task automatic test_empty_replay();
    int notes = 0;
    a_cmd(1, 0, 0, 2'b01, 8000);
    checks++;
    if (ifa.o_count !== 7'd0) begin
      errors++;
      $display("FAIL arm_press: got count %0d, expected 0", ifa.o_count);
    end
    a_cmd(0, 0, 1, 2'b00, 8001);
    checks++;
    if (ifa.o_recording !== 1'b1) begin
      errors++;
      $display("FAIL replay_in_rec: got rec %b, expected 1", ifa.o_recording);
    end
    a_cmd(0, 1, 0, 2'b00, 8002);
    checks++;
    if (ifa.o_recording !== 1'b0 || ifa.o_game_end !== 1'b0) begin
      errors++;
      $display("FAIL empty_stop: got rec %b end %b, expected 0 0", ifa.o_recording, ifa.o_game_end);
    end
    a_cmd(0, 0, 1, 2'b00, 8003);
    checks++;
    if (ifa.o_game_end !== 1'b1) begin
      errors++;
      $display("FAIL empty_replay_end: got %b, expected 1", ifa.o_game_end);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifa.o_note_t1 || ifa.o_note_t2) notes++;
    end
    a_cmd(0, 1, 0, 2'b00, 8010);
    checks++;
    if (notes != 0 || ifa.o_game_end !== 1'b1) begin
      errors++;
      $display("FAIL empty_quiet: got %0d notes end %b, expected 0 and 1", notes, ifa.o_game_end);
    end
  endtask

  task automatic test_reset_mid_play();
    int n = 0;
    int bad = 0;
    a_cmd(1, 0, 0, 2'b00, 10000);
    a_cmd(0, 0, 0, 2'b01, 10010);
    a_cmd(0, 0, 0, 2'b10, 10020);
    a_cmd(0, 0, 0, 2'b01, 10030);
    a_cmd(0, 1, 0, 2'b00, 10031);
    a_cmd(0, 0, 1, 2'b00, 11000);
    for (int t = 11000; t < 11200 && n < 2; t++) begin
      ifa.i_cur_time = t;
      tick();
      if (ifa.o_note_t1 || ifa.o_note_t2) n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL mid_play_notes: got %0d notes before timeout, expected 2", n);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ifa.o_note_t1, ifa.o_note_t2, ifa.o_game_end, ifa.o_recording, ifa.o_overflow} !== 5'b0
        || ifa.o_count !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: got flags %b count %0d, expected 00000 and 0",
               {ifa.o_note_t1, ifa.o_note_t2, ifa.o_game_end, ifa.o_recording, ifa.o_overflow}, ifa.o_count);
    end
    tick();
    rst = 1'b1;
    a_cmd(0, 0, 1, 2'b00, 12000);
    for (int t = 12000; t < 12040; t++) begin
      ifa.i_cur_time = t;
      tick();
      if (ifa.o_note_t1 || ifa.o_note_t2 || ifa.o_game_end || ifa.o_recording) bad++;
    end
    checks++;
    if (bad != 0 || ifa.o_count !== 7'd0) begin
      errors++;
      $display("FAIL replay_after_reset: got %0d active cycles count %0d, expected 0 and 0",
               bad, ifa.o_count);
    end
  endtask

  initial begin
    ifa.i_cur_time = 0; ifa.i_arm = 0; ifa.i_stop = 0; ifa.i_replay = 0; ifa.i_play = 0;
    ifb.i_cur_time = 0; ifb.i_arm = 0; ifb.i_stop = 0; ifb.i_replay = 0; ifb.i_play = 0;
    test_reset();
    test_record_replay();
    test_merge();
    test_full();
    test_saturation();
    test_empty_replay();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
